// File: rtl/xgmii_split_64b32b_fifo.sv
// ---------------------------------------------------------------------------
// xgmii_split_64b32b_fifo
//
// Purpose:
//   Single-clock XGMII width converter. 64-bit XGMII words are buffered in a
//   small FIFO and re-emitted as two 32-bit XGMII words, low half first.
//   This is the return path of the 32b-to-64b retransmit FIFO.
//
// Parameters:
//   FIFO_DEPTH : number of 64-bit entries (power of two, >= 2)
//
// Ports:
//   clk    in   single clock
//   rst    in   asynchronous active-high reset
//   rx     in   xgmii64_t input word, valid when rx.ena = 1
//   rx_rdy out  !rst && !full (advisory, not enforced)
//   tx     out  xgmii32_t registered output word
//   level  out  number of FIFO entries held (0..FIFO_DEPTH)
//   ovf    out  sticky overflow flag, cleared only by rst
//
// Configuration macro:
//   XGMII_SPLIT_IDLE_FILL_EN : when defined, an empty FIFO emits XGMII idle
//   (ena=1, ctrl=4'hF, data=32'h07070707) instead of ena=0 with held lanes.
// ---------------------------------------------------------------------------
package xgmii_split_pkg;
  typedef struct packed {
    logic        ena;
    logic [7:0]  ctrl;
    logic [63:0] data;
  } xgmii64_t;

  typedef struct packed {
    logic        ena;
    logic [3:0]  ctrl;
    logic [31:0] data;
  } xgmii32_t;
endpackage

module xgmii_split_64b32b_fifo
  import xgmii_split_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  xgmii64_t      rx,
  output logic          rx_rdy,
  output xgmii32_t      tx,
  output logic [AW:0]   level,
  output logic          ovf
);

  typedef enum logic {
    LO = 1'b0,
    HI = 1'b1
  } state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  // Entry layout: {ctrl[7:0], data[63:0]}
  logic [71:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic          ovf_r;
  state_t        state_r;
  state_t        state_nxt_s;
  xgmii32_t      tx_r;
  xgmii32_t      tx_nxt_s;
  logic [71:0]   head_s;
  logic          full_s;
  logic          empty_s;
  logic          wr_en_s;
  logic          pop_s;

  // Fullness is judged on the pre-edge level, so a same-edge pop never
  // rescues a write that arrives while full.
  assign full_s  = (level_r == DEPTH_L);
  assign empty_s = (level_r == {(AW+1){1'b0}});
  assign wr_en_s = rx.ena & ~full_s;
  assign head_s  = mem_r[rd_ptr_r];

  assign rx_rdy = ~rst & ~full_s;
  assign tx     = tx_r;
  assign level  = level_r;
  assign ovf    = ovf_r;

  // Serializer next-state and next-output decode.
  always_comb begin
    state_nxt_s = state_r;
    tx_nxt_s    = tx_r;
    pop_s       = 1'b0;
    case (state_r)
      LO: begin
        if (!empty_s) begin
          tx_nxt_s.ena  = 1'b1;
          tx_nxt_s.ctrl = head_s[67:64];
          tx_nxt_s.data = head_s[31:0];
          state_nxt_s   = HI;
        end else begin
`ifdef XGMII_SPLIT_IDLE_FILL_EN
          tx_nxt_s.ena  = 1'b1;
          tx_nxt_s.ctrl = 4'hF;
          tx_nxt_s.data = 32'h07070707;
`else
          // Lanes hold their previous value; only ena drops.
          tx_nxt_s.ena  = 1'b0;
`endif
          state_nxt_s   = LO;
        end
      end
      HI: begin
        // HI is only entered from LO with a non-empty FIFO, and level cannot
        // fall in between, so the head entry is still valid here.
        tx_nxt_s.ena  = 1'b1;
        tx_nxt_s.ctrl = head_s[71:68];
        tx_nxt_s.data = head_s[63:32];
        pop_s         = 1'b1;
        state_nxt_s   = LO;
      end
      default: begin
        state_nxt_s = LO;
      end
    endcase
  end

  // Control state: FSM, pointers, occupancy, overflow flag and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= LO;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
      ovf_r    <= 1'b0;
      tx_r     <= '{ena: 1'b0, ctrl: 4'h0, data: 32'h0000_0000};
    end else begin
      state_r <= state_nxt_s;
      tx_r    <= tx_nxt_s;
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (rx.ena && full_s) begin
        ovf_r <= 1'b1;
      end
      case ({wr_en_s, pop_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= {rx.ctrl, rx.data};
    end
  end

endmodule

// File: tb/tb_xgmii_split_64b32b_fifo.sv
// ---------------------------------------------------------------------------
// tb_xgmii_split_64b32b_fifo
//
// Directed self-checking bench for xgmii_split_64b32b_fifo (FIFO_DEPTH = 4).
// Expected output words are built from the input words using the lane
// mapping (low half = data[31:0]/ctrl[3:0], high half = data[63:32]/ctrl[7:4]).
// Honours XGMII_SPLIT_IDLE_FILL_EN for the empty-output expectations.
// ---------------------------------------------------------------------------
module tb_xgmii_split_64b32b_fifo;
  import xgmii_split_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic        clk;
  logic        rst;
  xgmii64_t    rx;
  logic        rx_rdy;
  xgmii32_t    tx;
  logic [AW:0] level;
  logic        ovf;

  int checks;
  int errors;

  logic [35:0] got_q [$];
  logic [35:0] exp_q [$];

  xgmii_split_64b32b_fifo #(.FIFO_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .rx_rdy (rx_rdy),
    .tx     (tx),
    .level  (level),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic xgmii64_t mk(input int id);
    xgmii64_t w;
    w.ena  = 1'b1;
    w.ctrl = 8'(id * 7 + 1);
    w.data = {16'hC0DE, 16'(id), 16'hA5A5, 16'(id)};
    return w;
  endfunction

  function automatic logic [35:0] lo_of(input xgmii64_t w);
    return {w.ctrl[3:0], w.data[31:0]};
  endfunction

  function automatic logic [35:0] hi_of(input xgmii64_t w);
    return {w.ctrl[7:4], w.data[63:32]};
  endfunction

  // Advance one clock, sample 1 time unit later, collect any data word.
  task automatic tick(output bit got_data);
    @(posedge clk);
    #1;
    got_data = 1'b0;
    if (tx.ena === 1'b1 && !(tx.ctrl === 4'hF && tx.data === 32'h07070707)) begin
      got_q.push_back({tx.ctrl, tx.data});
      got_data = 1'b1;
    end
  endtask

  task automatic do_reset();
    bit g;
    rx  = '0;
    rst = 1'b1;
    tick(g);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rx  = '0;
    rst = 1'b1;
    #2;
    checks++;
    if (tx !== 37'h0 || level !== 3'd0 || ovf !== 1'b0 || rx_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tx=%h level=%0d ovf=%b rx_rdy=%b, required tx=0 level=0 ovf=0 rx_rdy=0",
               tx, level, ovf, rx_rdy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (rx_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_rdy: rx_rdy=%b required 1", rx_rdy);
    end
  endtask

  task automatic test_single();
    bit g;
    do_reset();
    rx = {1'b1, 8'h01, 64'h0706050403020100};
    tick(g);
    rx = '0;
    checks++;
    if (level !== 3'd1) begin
      errors++;
      $display("FAIL single_level_e0: level=%0d required 1", level);
    end
    tick(g);
    checks++;
    if (tx !== {1'b1, 4'h1, 32'h03020100}) begin
      errors++;
      $display("FAIL single_lo: tx=%h required %h", tx, {1'b1, 4'h1, 32'h03020100});
    end
    tick(g);
    checks++;
    if (tx !== {1'b1, 4'h0, 32'h07060504}) begin
      errors++;
      $display("FAIL single_hi: tx=%h required %h", tx, {1'b1, 4'h0, 32'h07060504});
    end
    checks++;
    if (level !== 3'd0) begin
      errors++;
      $display("FAIL single_level_e2: level=%0d required 0", level);
    end
    tick(g);
    checks++;
`ifdef XGMII_SPLIT_IDLE_FILL_EN
    if (tx !== {1'b1, 4'hF, 32'h07070707}) begin
      errors++;
      $display("FAIL single_after: tx=%h required idle %h", tx, {1'b1, 4'hF, 32'h07070707});
    end
`else
    if (tx !== {1'b0, 4'h0, 32'h07060504}) begin
      errors++;
      $display("FAIL single_after: tx=%h required held %h", tx, {1'b0, 4'h0, 32'h07060504});
    end
`endif
  endtask

  task automatic test_half_rate();
    bit g;
    int gaps;
    int max_level;
    do_reset();
    gaps = 0;
    max_level = 0;
    for (int i = 0; i < 100; i++) begin
      rx = mk(i);
      exp_q.push_back(lo_of(mk(i)));
      exp_q.push_back(hi_of(mk(i)));
      for (int c = 0; c < 2; c++) begin
        tick(g);
        rx = '0;
        if (int'(level) > max_level) max_level = int'(level);
        if (!g && got_q.size() > 0 && got_q.size() < 200) gaps++;
      end
    end
    for (int c = 0; c < 4; c++) tick(g);
    checks++;
    if (got_q.size() != 200) begin
      errors++;
      $display("FAIL half_count: got %0d words required 200", got_q.size());
    end
    for (int i = 0; i < 200 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL half_word[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (gaps != 0) begin
      errors++;
      $display("FAIL half_contiguous: gaps=%0d required 0", gaps);
    end
    checks++;
    if (max_level > 1) begin
      errors++;
      $display("FAIL half_max_level: max=%0d required <=1", max_level);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL half_ovf: ovf=%b required 0", ovf);
    end
  endtask

  task automatic test_overflow();
    bit g;
    do_reset();
    // Words 6, 8 and 10 arrive while level is 4 and are dropped.
    for (int i = 0; i < 12; i++) begin
      rx = mk(i);
      if (i != 6 && i != 8 && i != 10) begin
        exp_q.push_back(lo_of(mk(i)));
        exp_q.push_back(hi_of(mk(i)));
      end
      tick(g);
      if (i == 5) begin
        checks++;
        if (level !== 3'd4 || ovf !== 1'b0 || rx_rdy !== 1'b0) begin
          errors++;
          $display("FAIL ovf_full: level=%0d ovf=%b rx_rdy=%b required 4 0 0", level, ovf, rx_rdy);
        end
      end
      if (i == 6) begin
        checks++;
        if (ovf !== 1'b1) begin
          errors++;
          $display("FAIL ovf_rise: ovf=%b required 1", ovf);
        end
      end
    end
    rx = '0;
    for (int c = 0; c < 20; c++) tick(g);
    checks++;
    if (got_q.size() != 18) begin
      errors++;
      $display("FAIL ovf_count: got %0d words required 18", got_q.size());
    end
    for (int i = 0; i < 18 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ovf_word[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (ovf !== 1'b1 || level !== 3'd0) begin
      errors++;
      $display("FAIL ovf_sticky: ovf=%b level=%0d required 1 0", ovf, level);
    end
  endtask

  task automatic test_wrap();
    bit g;
    int gap_tab [12] = '{0, 1, 0, 1, 2, 0, 1, 0, 1, 3, 0, 1};
    do_reset();
    for (int i = 0; i < 3 * DEPTH; i++) begin
      rx = mk(100 + i);
      exp_q.push_back(lo_of(mk(100 + i)));
      exp_q.push_back(hi_of(mk(100 + i)));
      tick(g);
      rx = '0;
      for (int c = 0; c < gap_tab[i]; c++) tick(g);
    end
    for (int c = 0; c < 12; c++) tick(g);
    checks++;
    if (got_q.size() != 24) begin
      errors++;
      $display("FAIL wrap_count: got %0d words required 24", got_q.size());
    end
    for (int i = 0; i < 24 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL wrap_word[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (level !== 3'd0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: level=%0d ovf=%b required 0 0", level, ovf);
    end
  endtask

  task automatic test_reset_mid();
    bit g;
    do_reset();
    rx = mk(50);
    tick(g);
    rx = '0;
    tick(g);
    checks++;
    if ({tx.ctrl, tx.data} !== lo_of(mk(50)) || tx.ena !== 1'b1) begin
      errors++;
      $display("FAIL mid_lo_before: tx=%h required lo %h", tx, lo_of(mk(50)));
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tx.ena !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL mid_async: tx.ena=%b level=%0d required 0 0", tx.ena, level);
    end
    tick(g);
    rst = 1'b0;
    got_q.delete();
    for (int c = 0; c < 3; c++) tick(g);
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL mid_no_hi: got %0d data words required 0", got_q.size());
    end
    rx = mk(51);
    tick(g);
    rx = '0;
    tick(g);
    checks++;
    if ({tx.ctrl, tx.data} !== lo_of(mk(51)) || tx.ena !== 1'b1) begin
      errors++;
      $display("FAIL mid_next_lo: tx=%h required lo %h", tx, lo_of(mk(51)));
    end
  endtask

  task automatic test_empty_output();
    bit g;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      tick(g);
      checks++;
`ifdef XGMII_SPLIT_IDLE_FILL_EN
      if (tx !== {1'b1, 4'hF, 32'h07070707}) begin
        errors++;
        $display("FAIL empty_idle[%0d]: tx=%h required %h", c, tx, {1'b1, 4'hF, 32'h07070707});
      end
`else
      if (tx.ena !== 1'b0) begin
        errors++;
        $display("FAIL empty_ena[%0d]: tx.ena=%b required 0", c, tx.ena);
      end
`endif
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    rx     = '0;
    test_reset();
    test_single();
    test_half_rate();
    test_overflow();
    test_wrap();
    test_reset_mid();
    test_empty_output();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
